// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - nibble-serial multi-precision adder around one shared 4-bit adder
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module binary_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  assign {c_out, sum} = a + b + {3'b000, c_in};
endmodule

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                 ovf
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W-1:0]  work_q, work_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d, c_out_q, c_out_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [3:0]    add_a, add_b, add_sum;
  logic          add_cout;
  logic [W-1:0]  merged;
  logic [IW+1:0] shamt;

  assign shamt = {idx_q, 2'b00};
  assign add_a = 4'(op_a_q >> shamt);
  assign add_b = 4'(op_b_q >> shamt);

  binary_adder u_adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Current nibble's sum spliced into the partial work word; on the final
  // nibble this is the complete result.
  assign merged = (work_q & ~(W'(4'hF) << shamt)) | (W'(add_sum) << shamt);

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = c_in;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        work_d  = merged;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = merged;
          c_out_d = add_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) && (merged[W-1] != op_a_q[W-1]);
`endif
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (NIBBLES=4 and NIBBLES=1)

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start4 = 1'b0, c4 = 1'b0, busy4, done4, cout4;
  logic [15:0] a4 = '0, b4 = '0, sum4;
  logic        start1 = 1'b0, c1 = 1'b0, busy1, done1, cout1;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf4, ovf1;
`endif

  serial_add_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ndone4   = 0;
  int ndone1   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a request is a W+1-bit sum that appears NIBBLES edges after acceptance.
  logic        m4_busy = 0, m4_done = 0, m4_cout = 0, m4_ovf = 0, m4_povf = 0;
  logic [15:0] m4_sum = '0;
  logic [16:0] m4_pend = '0;
  int          m4_cnt = 0;
  logic        m1_busy = 0, m1_done = 0, m1_cout = 0, m1_ovf = 0, m1_povf = 0;
  logic [3:0]  m1_sum = '0;
  logic [4:0]  m1_pend = '0;
  int          m1_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4_busy = 0; m4_done = 0; m4_cout = 0; m4_ovf = 0; m4_sum = '0; m4_cnt = 0;
      m1_busy = 0; m1_done = 0; m1_cout = 0; m1_ovf = 0; m1_sum = '0; m1_cnt = 0;
    end else begin
      m4_done = 0;
      if (!m4_busy) begin
        if (start4) begin
          m4_busy = 1; m4_cnt = 4;
          m4_pend = {1'b0, a4} + {1'b0, b4} + 17'(c4);
          m4_povf = (a4[15] == b4[15]) && (m4_pend[15] != a4[15]);
        end
      end else begin
        m4_cnt--;
        if (m4_cnt == 0) begin
          m4_busy = 0; m4_done = 1; {m4_cout, m4_sum} = m4_pend; m4_ovf = m4_povf;
        end
      end
      m1_done = 0;
      if (!m1_busy) begin
        if (start1) begin
          m1_busy = 1; m1_cnt = 1;
          m1_pend = {1'b0, a1} + {1'b0, b1} + 5'(c1);
          m1_povf = (a1[3] == b1[3]) && (m1_pend[3] != a1[3]);
        end
      end else begin
        m1_cnt--;
        if (m1_cnt == 0) begin
          m1_busy = 0; m1_done = 1; {m1_cout, m1_sum} = m1_pend; m1_ovf = m1_povf;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy4", busy4, m4_busy);
      chk("done4", done4, m4_done);
      chk("sum4", sum4, m4_sum);
      chk("cout4", cout4, m4_cout);
      chk("excl4", busy4 & done4, 0);
      chk("busy1", busy1, m1_busy);
      chk("done1", done1, m1_done);
      chk("sum1", sum1, m1_sum);
      chk("cout1", cout1, m1_cout);
      chk("excl1", busy1 & done1, 0);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf4", ovf4, m4_ovf);
      chk("ovf1", ovf1, m1_ovf);
`endif
      if (done4) ndone4++;
      if (done1) ndone1++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done4(output int busy_cycles, output int lat);
    busy_cycles = 0;
    lat = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busy_cycles++;
      step();
      lat++;
    end
    chk("timeout4", done4, 1);
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c,
                     output int busy_cycles, output int lat);
    start4 = 1; a4 = a; b4 = b; c4 = c;
    step();
    start4 = 0; a4 = 16'($urandom); b4 = 16'($urandom); c4 = 1'($urandom);
    wait_done4(busy_cycles, lat);
  endtask

  int bc, lat, d0;

  initial begin
    step(); step();
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_sum4", sum4, 0);
    chk("rst_cout4", cout4, 0);
    rst = 0;
    step();

    d0 = ndone4;
    op4(16'h1234, 16'h4321, 1'b0, bc, lat);
    chk("t1_busy_cycles", bc, 4);
    chk("t1_latency", lat, 4);
    chk("t1_sum", sum4, 16'h5555);
    chk("t1_cout", cout4, 0);
    chk("t1_model_sum", m4_sum, 16'h5555);
    step(); step();
    chk("t1_done_once", ndone4 - d0, 1);

    op4(16'hFFFF, 16'h0001, 1'b0, bc, lat);
    chk("t2_sum", sum4, 16'h0000);
    chk("t2_cout", cout4, 1);
    chk("t2_model_cout", m4_cout, 1);
    step();

    start1 = 1; a1 = 4'h9; b1 = 4'h7; c1 = 1'b1;
    step();
    start1 = 0; a1 = 4'h0; b1 = 4'h0; c1 = 1'b0;
    chk("n1_busy", busy1, 1);
    step();
    chk("n1_done", done1, 1);
    chk("n1_sum", sum1, 4'h1);
    chk("n1_cout", cout1, 1);
    chk("n1_model_sum", m1_sum, 4'h1);
    step();

    d0 = ndone4;
    start4 = 1; a4 = 16'h0101; b4 = 16'h0202; c4 = 0;
    step();
    start4 = 0; a4 = 16'h0000; b4 = 16'h0000;
    step();
    start4 = 1; a4 = 16'hFFFF;
    step();
    start4 = 0;
    wait_done4(bc, lat);
    chk("bz_sum", sum4, 16'h0303);
    chk("bz_latency", lat, 2);
    chk("bz_done_once", ndone4 - d0, 1);
    start4 = 1; a4 = 16'h1111; b4 = 16'h2222; c4 = 1;
    step();
    start4 = 0;
    chk("b2b_busy", busy4, 1);
    chk("b2b_hold", sum4, 16'h0303);
    wait_done4(bc, lat);
    chk("b2b_latency", lat, 4);
    chk("b2b_sum", sum4, 16'h3334);
    step();

    start4 = 1; a4 = 16'hAAAA; b4 = 16'h1111; c4 = 0;
    step();
    start4 = 0;
    step(); step();
    d0 = ndone4;
    #2 rst = 1;
    #1;
    chk("rst_mid_busy", busy4, 0);
    chk("rst_mid_done", done4, 0);
    chk("rst_mid_sum", sum4, 0);
    chk("rst_mid_cout", cout4, 0);
    step();
    rst = 0;
    step(); step(); step(); step(); step();
    chk("rst_no_done", ndone4 - d0, 0);
    op4(16'h8000, 16'h8000, 1'b1, bc, lat);
    chk("post_rst_sum", sum4, 16'h0001);
    chk("post_rst_cout", cout4, 1);
    step();

`ifdef SERIAL_ADD_OVF_EN
    op4(16'h7FFF, 16'h0001, 1'b0, bc, lat);
    chk("ovf_a_sum", sum4, 16'h8000);
    chk("ovf_a_ovf", ovf4, 1);
    chk("ovf_a_cout", cout4, 0);
    op4(16'hFFFF, 16'h0001, 1'b0, bc, lat);
    chk("ovf_b_ovf", ovf4, 0);
    chk("ovf_b_cout", cout4, 1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Nibble-serial multi-precision adder controller. Adds two W-bit operands (W = 4×NIBBLES) by sequencing one shared instance of the team's four-bit dataflow adder (binary_adder), least-significant nibble first, with the carry chained through a register between cycles. It sits between a requester using a start/done handshake and the four-bit adder datapath. It trades latency for area when wider sums are needed.

## Interface

Parameters:
- NIBBLES, default 4: operand width in nibbles; W = 4×NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  W  operand A; sampled on the accepting edge only.
- b  input  W  operand B; sampled on the accepting edge only.
- c_in  input  1  carry into nibble 0; sampled on the accepting edge only.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when the result is updated.
- sum  output  W  result register; holds the last completed result.
- c_out  output  1  carry out of the top nibble of the last result.
- ovf  output  1  signed overflow of the last result; present only with SERIAL_ADD_OVF_EN.

## Operation

- States: IDLE and ADD.
- Registers: opA and opB (W), carry (1), idx (counts 0..NIBBLES-1), work (W).
- Reset values: state=IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, and all internal registers 0.
- IDLE, start=1: latch a, b into opA, opB; carry←c_in; idx←0; busy←1; go to ADD.
- ADD, each edge:
  - Present opA[4·idx+:4], opB[4·idx+:4] and carry to the adder.
  - work[4·idx+:4]←adder Sum; carry←adder C_out; idx←idx+1.
- ADD, at idx=NIBBLES-1 (final nibble):
  - sum←work with the final nibble merged in; c_out←adder C_out.
  - done←1; busy←0; go to IDLE.
- Arithmetic: {c_out, sum} = a + b + c_in, modulo 2^(W+1); this must be bit-exact to a single W-bit add.
- start while busy=1 is ignored; there is no queueing.
- Operands may change freely after the accepting edge.
- sum and c_out never show partial results; they update atomically on the final edge only.
- rst mid-operation: the operation is abandoned; all outputs return to reset values immediately; no done pulse is produced.

## Timing

- Accepting edge T (IDLE, start=1): busy=1 from T until the final edge.
- The final ADD edge is T+NIBBLES; sum, c_out and ovf are valid from then on.
- done is high for exactly the one cycle following edge T+NIBBLES.
- Latency: NIBBLES cycles from the accepting edge to the result.
- Back-to-back operation: start asserted in the done cycle is accepted at edge T+NIBBLES+1 (state is IDLE). The previous result holds until the new final edge.
- NIBBLES=1: a single ADD edge; done pulses in the cycle after T+1.
- done and busy are never high in the same cycle.

## Configuration

- SERIAL_ADD_OVF_EN defined:
  - ovf port exists.
  - On the final edge, ovf←(a[W-1]==b[W-1]) && (result[W-1]!=a[W-1]).
  - ovf holds with sum and resets to 0.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

## Test plan

- NIBBLES=4, a=16'h1234, b=16'h4321, c_in=0, start one cycle:
  - busy high for 4 cycles.
  - done pulses once.
  - sum=16'h5555, c_out=0.
- NIBBLES=4, a=16'hFFFF, b=16'h0001, c_in=0:
  - Carry ripples through all nibbles.
  - sum=16'h0000, c_out=1.
- NIBBLES=1, a=4'h9, b=4'h7, c_in=1:
  - Result after 1 cycle: sum=4'h1, c_out=1, matching the standalone adder.
- Start while busy:
  - Issue a=16'h0101, b=16'h0202; at cycle 2 pulse start with a=16'hFFFF.
  - Second request ignored; sum=16'h0303; exactly one done pulse.
  - Then start in the done cycle: the new request is accepted with no gap.
- Reset mid-operation:
  - Assert rst asynchronously during idx=2.
  - busy, done, sum and c_out are 0 immediately.
  - No done pulse; the next start completes normally.
- With SERIAL_ADD_OVF_EN:
  - a=16'h7FFF, b=16'h0001 → sum=16'h8000, ovf=1, c_out=0.
  - a=16'hFFFF, b=16'h0001 → ovf=0, c_out=1.
